e_mdu: RTL
==========

// Module: e_mdu
// PURPOSE
//  Multi-cycle multiply/divide unit with HI/LO registers, sitting beside E_ALU in stage E.
//  Sequences mult/multu/div/divu over a fixed latency and serves mfhi/mflo/mthi/mtlo.
//  Raises md_stall so the stall unit can hold a D-stage HI/LO or md instruction while the
//  unit is started or busy; stage-E forwarded operands feed it directly.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for mult/multu (>=1)
//  DIV_CYCLES   10  busy cycles for div/divu (>=1)
// PORTS
//  clk        in   1   system clock; all state changes on posedge
//  reset      in   1   synchronous, active-high; clears all state
//  MDUop      in   4   E-stage op: 0 NONE,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MFHI,6 MFLO,7 MTHI,8 MTLO
//  A          in   32  forwarded rs value (E_rs_ndata)
//  B          in   32  forwarded rt value (E_rt_ndata)
//  D_md_use   in   1   D-stage instr is any md op (1..8)
//  start      out  1   comb: MDUop in {1..4} and state IDLE
//  busy       out  1   registered: unit in RUN
//  md_stall   out  1   comb: D_md_use & (start | busy)
//  MDU_out    out  32  comb: MFHI->HI, MFLO->LO, else 0
// BEHAVIOUR
//  - Reset: state IDLE, cnt 0, HI 0, LO 0, pending 0; busy 0; MDU_out 0 unless MFHI/MFLO.
//  - FSM IDLE: start at edge t -> latch pending {HI,LO} result, cnt=N-1 (N per op), go RUN.
//    busy is 1 in cycles t+1..t+N. RUN: cnt!=0 -> cnt-1; cnt==0 -> commit pending to HI/LO,
//    go IDLE. HI/LO visible (busy 0) from cycle t+N+1.
//  - MULT: {HI,LO}=signed 64-bit A*B. MULTU: unsigned 64-bit product.
//  - DIV: LO=signed A/B truncated toward zero, HI=remainder, sign of A. DIVU: unsigned.
//  - B==0 on DIV/DIVU: FSM runs full DIV_CYCLES, busy as normal, commit leaves HI/LO unchanged.
//  - DIV 0x80000000 / -1: LO=0x80000000, HI=0 (wraps, no trap).
//  - MTHI/MTLO in IDLE: HI (resp. LO) <= A at edge. md_stall makes MTHI/MTLO/MFHI/MFLO/start
//    while busy impossible; if they occur they are ignored (no state change), MDU_out still
//    shows current HI/LO.
//  - Start op at the commit edge (cnt==0 in RUN) is ignored; md_stall prevents this.
//  - Stall bubbles in E carry MDUop NONE: no state change.
//  - reset mid-RUN: next cycle busy 0, HI/LO 0, pending discarded, no late commit.
//  - reset and start same cycle: reset wins.
//  - Widths: products 64-bit via $signed / zero-extended operands; cnt width
//    $clog2(max(MULT_CYCLES,DIV_CYCLES)+1).
// STRUCTURE
//  - MDUop encodings (MDU_NONE..MDU_MTLO) live in the shared opcode/control-constant
//    package used by CU; CU decodes them in stage E.
//  - FSM state encodings (ST_IDLE, ST_RUN) stay local to this module.
//  - Single module; arithmetic is behavioural multiply/divide. No sub-module is needed.
// TESTING
//  1 MULT A=3, B=0xFFFFFFFE -> busy 1 for 5 cycles;
//    then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
//  2 MULTU A=0xFFFFFFFF, B=2 -> HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
//  3 DIV A=0xFFFFFFF9 (-7), B=2 -> busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//    Then DIVU 7/0 -> HI/LO unchanged.
//  4 MTHI A=0x1234, next cycle MFHI -> MDU_out=0x00001234.
//    MTLO A=5, MFLO -> MDU_out=0x00000005.
//  5 MULT start with D_md_use=1 held -> md_stall 1 for 1+5=6 cycles, 0 on the 7th;
//    D_md_use=0 -> md_stall stays 0.
//  6 DIV started, reset asserted on 3rd busy cycle -> busy 0, HI=LO=0 next cycle;
//    no commit afterwards.

Source files
------------

// File: rtl/e_mdu_pkg.sv
// Shared opcode constants for the stage-E multiply/divide unit, also used by CU.
package e_mdu_pkg;

  typedef logic [3:0] mdu_op_t;

  localparam mdu_op_t MDU_NONE  = 4'd0;
  localparam mdu_op_t MDU_MULT  = 4'd1;
  localparam mdu_op_t MDU_MULTU = 4'd2;
  localparam mdu_op_t MDU_DIV   = 4'd3;
  localparam mdu_op_t MDU_DIVU  = 4'd4;
  localparam mdu_op_t MDU_MFHI  = 4'd5;
  localparam mdu_op_t MDU_MFLO  = 4'd6;
  localparam mdu_op_t MDU_MTHI  = 4'd7;
  localparam mdu_op_t MDU_MTLO  = 4'd8;

  // True for the ops that occupy the unit for several cycles.
  function automatic logic is_md_start(input mdu_op_t op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/e_mdu.sv
// Multi-cycle multiply/divide unit with HI/LO registers for stage E.
// The result is computed when the op starts and held in a pending register
// until the busy window expires, then committed to HI/LO.
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MDUop,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        D_md_use,
  output logic        start,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] MDU_out
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic {ST_IDLE, ST_RUN} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, lo_q;
  logic [31:0]      pend_hi_q, pend_lo_q;
  logic             pend_wr_q;
  logic             is_div;
  logic             commit;
  logic [63:0]      res;

  // 64-bit product; signed form sign-extends both operands.
  function automatic logic [63:0] mul_calc(input logic [31:0] a, input logic [31:0] b,
                                           input logic sgn);
    logic signed [63:0] sp;
    logic [63:0]        up;
    sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    up = {32'b0, a} * {32'b0, b};
    return sgn ? sp : up;
  endfunction

  // Returns {remainder, quotient}. Quotient truncates toward zero, remainder
  // takes the dividend's sign; the one overflowing signed case wraps.
  function automatic logic [63:0] div_calc(input logic [31:0] a, input logic [31:0] b,
                                           input logic sgn);
    logic signed [31:0] sa, sb, sq, sr;
    if (b == 32'h0) return 64'h0;
    if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
      sa = a;
      sb = b;
      sq = sa / sb;
      sr = sa % sb;
      return {sr, sq};
    end
    return {a % b, a / b};
  endfunction

  assign is_div   = (MDUop == MDU_DIV) || (MDUop == MDU_DIVU);
  assign start    = is_md_start(MDUop) && (state_q == ST_IDLE);
  assign busy     = (state_q == ST_RUN);
  assign md_stall = D_md_use & (start | busy);
  assign commit   = (state_q == ST_RUN) && (cnt_q == '0);
  assign res      = is_div ? div_calc(A, B, MDUop == MDU_DIV)
                           : mul_calc(A, B, MDUop == MDU_MULT);
  assign MDU_out  = (MDUop == MDU_MFHI) ? hi_q :
                    (MDUop == MDU_MFLO) ? lo_q : 32'h0;

  // Sequencer state and busy-window counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: load the op latency on start, count down, return to idle at zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          cnt_d   = is_div ? DIV_LOAD : MULT_LOAD;
        end
      end
      ST_RUN: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // HI/LO and pending result: capture on start, commit at end of run, moves only when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q      <= 32'h0;
      lo_q      <= 32'h0;
      pend_hi_q <= 32'h0;
      pend_lo_q <= 32'h0;
      pend_wr_q <= 1'b0;
    end else if (start) begin
      pend_hi_q <= res[63:32];
      pend_lo_q <= res[31:0];
      pend_wr_q <= !(is_div && (B == 32'h0));
    end else if (commit) begin
      if (pend_wr_q) begin
        hi_q <= pend_hi_q;
        lo_q <= pend_lo_q;
      end
      pend_wr_q <= 1'b0;
    end else if (state_q == ST_IDLE) begin
      if (MDUop == MDU_MTHI) hi_q <= A;
      if (MDUop == MDU_MTLO) lo_q <= A;
    end
  end

endmodule
